timer_1_sequencer: RTL and testbench



---
 rtl/timer_1_sequencer_pkg.sv | 55 +++++
 rtl/timer_1_sequencer_if.sv | 32 +++
 rtl/timer_1_sequencer_rr_arbiter.sv | 61 ++++++
 rtl/timer_1_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_timer_1_sequencer.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_1_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// timer_1_pkg
//   Shared definitions for the timer_1 sequencer: timer register map, control
//   word bit positions, the sequencer state type and a small bus-write record
//   used to build the registered Avalon-MM write outputs.
// -----------------------------------------------------------------------------
package timer_1_pkg;

    // timer_1 register indices
    localparam logic [2:0] ADDR_STATUS  = 3'd0;
    localparam logic [2:0] ADDR_CONTROL = 3'd1;
    localparam logic [2:0] ADDR_PERIODL = 3'd2;
    localparam logic [2:0] ADDR_PERIODH = 3'd3;
    localparam logic [2:0] ADDR_SNAPL   = 3'd4;
    localparam logic [2:0] ADDR_SNAPH   = 3'd5;

    // control register bit positions
    localparam int CTRL_ITO   = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_STOP  = 3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ARB,
        ST_WR_PL,
        ST_WR_PH,
        ST_WR_CTRL,
        ST_WAIT_IRQ,
        ST_WR_STOP,
        ST_CLR_STATUS,
        ST_DONE
    } seq_state_t;

    // One registered bus beat. wr_n is kept as its own flop so that every
    // timer-facing output comes straight from a register.
    typedef struct packed {
        logic        cs;
        logic        wr_n;
        logic [2:0]  addr;
        logic [15:0] data;
    } bus_wr_t;

    localparam bus_wr_t BUS_IDLE = '{cs: 1'b0, wr_n: 1'b1, addr: 3'd0, data: 16'h0000};

    function automatic bus_wr_t bus_write(input logic [2:0] addr, input logic [15:0] data);
        bus_wr_t b;
        b.cs   = 1'b1;
        b.wr_n = 1'b0;
        b.addr = addr;
        b.data = data;
        return b;
    endfunction

endpackage

// File: rtl/timer_1_sequencer_if.sv
// -----------------------------------------------------------------------------
// timer_1_sequencer_if
//   Avalon-MM write-only slave port of timer_1 plus its irq line.
//   master : driven by the sequencer (address/chipselect/write_n/writedata),
//            receives tmr_irq.
//   slave  : the timer side.
// -----------------------------------------------------------------------------
interface timer_1_sequencer_if;

    logic [2:0]  tmr_address;
    logic        tmr_chipselect;
    logic        tmr_write_n;
    logic [15:0] tmr_writedata;
    logic        tmr_irq;

    modport master (
        output tmr_address,
        output tmr_chipselect,
        output tmr_write_n,
        output tmr_writedata,
        input  tmr_irq
    );

    modport slave (
        input  tmr_address,
        input  tmr_chipselect,
        input  tmr_write_n,
        input  tmr_writedata,
        output tmr_irq
    );

endinterface

// File: rtl/timer_1_sequencer_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Round-robin arbiter over NUM_REQ requesters. The search starts at the
//   registered pointer and ascends with wrap; on 'advance' the pointer moves
//   to the slot after the current winner.
//   Ports:
//     clk, reset_n   clock, async active-low reset (pointer resets to 0)
//     req            request vector
//     advance        commit the current grant (move the pointer)
//     grant_any      at least one request present
//     grant_idx      index of the winner (valid when grant_any)
//     grant_onehot   one-hot winner, all zero when no request
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic               grant_any,
    output logic [IDX_W-1:0]   grant_idx,
    output logic [NUM_REQ-1:0] grant_onehot
);

    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W-1:0] rr_ptr_d;
    int               cand;

    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!grant_any && req[cand]) begin
                grant_any = 1'b1;
                grant_idx = IDX_W'(cand);
            end
        end
    end

    assign grant_onehot = grant_any ? (NUM_REQ'(1) << grant_idx) : '0;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (advance && grant_any) begin
            rr_ptr_d = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/timer_1_sequencer.sv
// -----------------------------------------------------------------------------
// timer_1_sequencer
//   Shares the single timer_1 interval timer between NUM_REQ requesters. The
//   granted requester's 32-bit period is programmed as a one-shot, the irq is
//   awaited (or the run is cancelled by the owner), status is cleared and a
//   one-cycle done pulse is returned to that requester.
//
//   Ports:
//     clk, reset_n     clock, async active-low reset
//     req_valid        per-requester request, held until req_ready
//     req_period       per-requester period, slice i = [32i+31:32i]
//     req_ready        one-hot accept pulse
//     req_cancel       abort; only the owner's bit, only while waiting for irq
//     done             one-hot completion pulse
//     done_cancelled   qualifies done: 1 = cancelled, 0 = expired
//     busy             high from ARB through CLR_STATUS
//     tmr              timer_1 Avalon-MM master port + irq
//
//   All outputs are registered. The output registers are loaded together with
//   the state register from the next-state decode, so an output belongs to the
//   state it is visible in (e.g. the PERIODL write is on the bus during WR_PL).
//
//   state         | meaning
//   --------------+-----------------------------------------------------------
//   IDLE          | no owner; any req_valid starts arbitration
//   ARB           | winner accepted (req_ready), owner and period latched
//   WR_PL         | writing period[15:0] to PERIODL
//   WR_PH         | writing period[31:16] to PERIODH
//   WR_CTRL       | writing START|ITO to CONTROL
//   WAIT_IRQ      | bus idle, waiting for irq or owner cancel
//   WR_STOP       | writing STOP to CONTROL (cancel path)
//   CLR_STATUS    | writing 0 to STATUS, clears timeout_occurred
//   DONE          | done pulse to owner, busy low
// -----------------------------------------------------------------------------
module timer_1_sequencer
    import timer_1_pkg::*;
#(
    parameter  int          NUM_REQ        = 2,
    parameter  logic [15:0] CTRL_START_VAL = 16'h0005,
    parameter  logic [15:0] CTRL_STOP_VAL  = 16'h0008,
    localparam int          IDX_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [32*NUM_REQ-1:0]  req_period,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ-1:0]     req_cancel,
    output logic [NUM_REQ-1:0]     done,
    output logic                   done_cancelled,
    output logic                   busy,
    timer_1_sequencer_if.master    tmr
);

    seq_state_t         state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [31:0]        period_q, period_d;
    logic               cancelled_q, cancelled_d;
    logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               done_cancelled_q, done_cancelled_d;
    logic               busy_q, busy_d;
    bus_wr_t            bus_q, bus_d;

    logic               arb_advance;
    logic               grant_any;
    logic [IDX_W-1:0]   grant_idx;
    logic [NUM_REQ-1:0] grant_onehot;
    logic [NUM_REQ-1:0] owner_onehot;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .clk          (clk),
        .reset_n      (reset_n),
        .req          (req_valid),
        .advance      (arb_advance),
        .grant_any    (grant_any),
        .grant_idx    (grant_idx),
        .grant_onehot (grant_onehot)
    );

    assign owner_onehot = NUM_REQ'(1) << owner_q;

    always_comb begin
        state_d          = state_q;
        owner_d          = owner_q;
        period_d         = period_q;
        cancelled_d      = cancelled_q;
        req_ready_d      = '0;
        done_d           = '0;
        done_cancelled_d = 1'b0;
        busy_d           = busy_q;
        bus_d            = BUS_IDLE;
        arb_advance      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Arbitration happens on the edge into ARB so that req_ready
                // is registered and visible during ARB itself.
                if (grant_any) begin
                    state_d     = ST_ARB;
                    arb_advance = 1'b1;
                    owner_d     = grant_idx;
                    period_d    = req_period[32*int'(grant_idx) +: 32];
                    cancelled_d = 1'b0;
                    req_ready_d = grant_onehot;
                    busy_d      = 1'b1;
                end
            end
            ST_ARB: begin
                if (period_q == 32'd0) begin
                    // Nothing to time: complete immediately without touching the timer.
                    state_d = ST_DONE;
                    done_d  = owner_onehot;
                    busy_d  = 1'b0;
                end else begin
                    state_d = ST_WR_PL;
                    bus_d   = bus_write(ADDR_PERIODL, period_q[15:0]);
                end
            end
            ST_WR_PL: begin
                state_d = ST_WR_PH;
                bus_d   = bus_write(ADDR_PERIODH, period_q[31:16]);
            end
            ST_WR_PH: begin
                // The PERIODH write force-reloads the counter in the same cycle
                // the start strobe lands; the timer gives start priority.
                state_d = ST_WR_CTRL;
                bus_d   = bus_write(ADDR_CONTROL, CTRL_START_VAL);
            end
            ST_WR_CTRL: begin
                state_d = ST_WAIT_IRQ;
            end
            ST_WAIT_IRQ: begin
                // irq wins over a simultaneous cancel: the period has expired.
                if (tmr.tmr_irq) begin
                    state_d     = ST_CLR_STATUS;
                    cancelled_d = 1'b0;
                    bus_d       = bus_write(ADDR_STATUS, 16'h0000);
                end else if (req_cancel[owner_q]) begin
                    state_d     = ST_WR_STOP;
                    cancelled_d = 1'b1;
                    bus_d       = bus_write(ADDR_CONTROL, CTRL_STOP_VAL);
                end
            end
            ST_WR_STOP: begin
                // Status is cleared after the stop so a timeout that slipped in
                // just before the stop does not leave irq asserted.
                state_d = ST_CLR_STATUS;
                bus_d   = bus_write(ADDR_STATUS, 16'h0000);
            end
            ST_CLR_STATUS: begin
                state_d          = ST_DONE;
                done_d           = owner_onehot;
                done_cancelled_d = cancelled_q;
                busy_d           = 1'b0;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= ST_IDLE;
            owner_q          <= '0;
            period_q         <= '0;
            cancelled_q      <= 1'b0;
            req_ready_q      <= '0;
            done_q           <= '0;
            done_cancelled_q <= 1'b0;
            busy_q           <= 1'b0;
            bus_q            <= BUS_IDLE;
        end else begin
            state_q          <= state_d;
            owner_q          <= owner_d;
            period_q         <= period_d;
            cancelled_q      <= cancelled_d;
            req_ready_q      <= req_ready_d;
            done_q           <= done_d;
            done_cancelled_q <= done_cancelled_d;
            busy_q           <= busy_d;
            bus_q            <= bus_d;
        end
    end

    assign req_ready          = req_ready_q;
    assign done               = done_q;
    assign done_cancelled     = done_cancelled_q;
    assign busy               = busy_q;
    assign tmr.tmr_chipselect = bus_q.cs;
    assign tmr.tmr_write_n    = bus_q.wr_n;
    assign tmr.tmr_address    = bus_q.addr;
    assign tmr.tmr_writedata  = bus_q.data;

endmodule

// File: tb/tb_timer_1_sequencer.sv
`timescale 1ns/1ps
module tb_timer_1_sequencer;

    localparam int N          = 2;
    localparam int OUT_IRQ    = 0;
    localparam int OUT_CANCEL = 1;
    localparam int OUT_RACE   = 2;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_cancel = '0;
    logic [32*N-1:0]  req_period = '0;
    logic [N-1:0]     req_ready;
    logic [N-1:0]     done;
    logic             done_cancelled;
    logic             busy;

    timer_1_sequencer_if tmr_bus();

    timer_1_sequencer #(.NUM_REQ(N)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_period     (req_period),
        .req_ready      (req_ready),
        .req_cancel     (req_cancel),
        .done           (done),
        .done_cancelled (done_cancelled),
        .busy           (busy),
        .tmr            (tmr_bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rr_model = 0;

    always @(posedge clk) cyc++;

    // Reference round-robin: first requesting index at or after rr_model, wrapping.
    function automatic int rr_pick(input logic [N-1:0] mask);
        for (int k = 0; k < N; k++) begin
            if (mask[(rr_model + k) % N]) return (rr_model + k) % N;
        end
        return 0;
    endfunction

    // Waits for the grant of requester w (already requesting), then follows the
    // whole transaction, checking every bus beat and the completion pulse.
    task automatic serve(input int w, input int outcome, input int dly, input bit poke_other,
                         output int rdy_cyc, output int done_cyc);
        logic [31:0]  p;
        logic [N-1:0] oh;
        logic [2:0]   ea[3];
        logic [15:0]  ed[3];
        bit           seen;
        bit           stray;
        p = req_period[32*w +: 32];
        oh = N'(1) << w;
        rdy_cyc = 0;
        done_cyc = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (req_ready != '0) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL grant_timeout: req=%0d got no req_ready want one", w);
            return;
        end
        rdy_cyc = cyc;
        total++;
        if (req_ready !== oh) begin
            bad++;
            $display("FAIL grant_onehot: got %b want %b", req_ready, oh);
        end
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_arb: got %b want 1", busy);
        end
        req_valid[w] = 1'b0;
        req_cancel = '0;
        rr_model = (w + 1) % N;

        if (p == 32'd0) begin
            stray = (tmr_bus.tmr_chipselect !== 1'b0);
            @(negedge clk);
            done_cyc = cyc;
            total++;
            if (done !== oh || done_cancelled !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL zero_done: got done=%b dc=%b busy=%b want done=%b dc=0 busy=0",
                         done, done_cancelled, busy, oh);
            end
            if (tmr_bus.tmr_chipselect !== 1'b0) stray = 1'b1;
            @(negedge clk);
            if (tmr_bus.tmr_chipselect !== 1'b0 || done !== '0) stray = 1'b1;
            total++;
            if (stray) begin
                bad++;
                $display("FAIL zero_no_bus: got bus or extra done activity want none");
            end
            return;
        end

        ea[0] = 3'd2; ed[0] = p[15:0];
        ea[1] = 3'd3; ed[1] = p[31:16];
        ea[2] = 3'd1; ed[2] = 16'h0005;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (!(tmr_bus.tmr_chipselect === 1'b1 && tmr_bus.tmr_write_n === 1'b0 &&
                  tmr_bus.tmr_address === ea[i] && tmr_bus.tmr_writedata === ed[i])) begin
                bad++;
                $display("FAIL setup_write%0d: got cs=%b wn=%b a=%0d d=%h want cs=1 wn=0 a=%0d d=%h",
                         i, tmr_bus.tmr_chipselect, tmr_bus.tmr_write_n, tmr_bus.tmr_address,
                         tmr_bus.tmr_writedata, ea[i], ed[i]);
            end
        end

        stray = 1'b0;
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            if (tmr_bus.tmr_chipselect !== 1'b0 || tmr_bus.tmr_write_n !== 1'b1 ||
                done !== '0 || busy !== 1'b1) stray = 1'b1;
            req_cancel = '0;
            if (poke_other && i == dly / 2) req_cancel[(w + 1) % N] = 1'b1;
        end
        req_cancel = '0;
        total++;
        if (stray) begin
            bad++;
            $display("FAIL wait_quiet: got bus/done activity or busy low while waiting want idle");
        end

        if (outcome != OUT_CANCEL) tmr_bus.tmr_irq = 1'b1;
        if (outcome != OUT_IRQ) req_cancel[w] = 1'b1;

        if (outcome == OUT_CANCEL) begin
            @(negedge clk);
            req_cancel = '0;
            total++;
            if (!(tmr_bus.tmr_chipselect === 1'b1 && tmr_bus.tmr_write_n === 1'b0 &&
                  tmr_bus.tmr_address === 3'd1 && tmr_bus.tmr_writedata === 16'h0008)) begin
                bad++;
                $display("FAIL stop_write: got cs=%b a=%0d d=%h want cs=1 a=1 d=0008",
                         tmr_bus.tmr_chipselect, tmr_bus.tmr_address, tmr_bus.tmr_writedata);
            end
        end

        @(negedge clk);
        tmr_bus.tmr_irq = 1'b0;
        req_cancel = '0;
        total++;
        if (!(tmr_bus.tmr_chipselect === 1'b1 && tmr_bus.tmr_write_n === 1'b0 &&
              tmr_bus.tmr_address === 3'd0 && tmr_bus.tmr_writedata === 16'h0000)) begin
            bad++;
            $display("FAIL clr_write: got cs=%b a=%0d d=%h want cs=1 a=0 d=0000",
                     tmr_bus.tmr_chipselect, tmr_bus.tmr_address, tmr_bus.tmr_writedata);
        end

        @(negedge clk);
        done_cyc = cyc;
        total++;
        if (done !== oh || done_cancelled !== (outcome == OUT_CANCEL) || busy !== 1'b0 ||
            tmr_bus.tmr_chipselect !== 1'b0) begin
            bad++;
            $display("FAIL done_pulse: got done=%b dc=%b busy=%b cs=%b want done=%b dc=%0d busy=0 cs=0",
                     done, done_cancelled, busy, tmr_bus.tmr_chipselect, oh, (outcome == OUT_CANCEL));
        end
    endtask

    task automatic test_reset();
        bit seen;
        bit stray;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (req_ready !== '0 || done !== '0 || done_cancelled !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctl: got rdy=%b done=%b dc=%b busy=%b want all 0",
                     req_ready, done, done_cancelled, busy);
        end
        total++;
        if (tmr_bus.tmr_chipselect !== 1'b0 || tmr_bus.tmr_write_n !== 1'b1 ||
            tmr_bus.tmr_address !== 3'd0 || tmr_bus.tmr_writedata !== 16'h0) begin
            bad++;
            $display("FAIL reset_bus: got cs=%b wn=%b a=%0d d=%h want 0 1 0 0000",
                     tmr_bus.tmr_chipselect, tmr_bus.tmr_write_n, tmr_bus.tmr_address,
                     tmr_bus.tmr_writedata);
        end
        reset_n = 1'b1;
        rr_model = 0;

        // Reset in the middle of WAIT_IRQ.
        req_period[31:0] = 32'd500;
        req_valid[0] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (req_ready[0]) seen = 1'b1;
        end
        req_valid[0] = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if (!seen || busy !== 1'b1) begin
            bad++;
            $display("FAIL midop_busy: got seen=%0d busy=%b want 1 1", seen, busy);
        end
        reset_n = 1'b0;
        #1;
        total++;
        if (req_ready !== '0 || done !== '0 || done_cancelled !== 1'b0 || busy !== 1'b0 ||
            tmr_bus.tmr_chipselect !== 1'b0 || tmr_bus.tmr_write_n !== 1'b1 ||
            tmr_bus.tmr_address !== 3'd0 || tmr_bus.tmr_writedata !== 16'h0) begin
            bad++;
            $display("FAIL midop_reset: got rdy=%b done=%b busy=%b cs=%b wn=%b want reset values",
                     req_ready, done, busy, tmr_bus.tmr_chipselect, tmr_bus.tmr_write_n);
        end
        @(negedge clk);
        reset_n = 1'b1;
        rr_model = 0;
        stray = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done !== '0 || busy !== 1'b0 || tmr_bus.tmr_chipselect !== 1'b0) stray = 1'b1;
        end
        total++;
        if (stray) begin
            bad++;
            $display("FAIL post_reset_idle: got activity after reset want idle");
        end

        // A stray irq while idle must not start anything.
        tmr_bus.tmr_irq = 1'b1;
        stray = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done !== '0 || busy !== 1'b0 || tmr_bus.tmr_chipselect !== 1'b0) stray = 1'b1;
        end
        tmr_bus.tmr_irq = 1'b0;
        total++;
        if (stray) begin
            bad++;
            $display("FAIL idle_irq: got activity on idle irq want none");
        end
    endtask

    task automatic test_single();
        int r, d;
        req_period[31:0] = 32'h0001_0010;
        req_valid[0] = 1'b1;
        serve(rr_pick(req_valid), OUT_IRQ, 32'h10012, 1'b0, r, d);
    endtask

    task automatic test_contention();
        int w, r0, d0, r1, d1, r2, d2;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        rr_model = 0;
        req_period = {32'd200, 32'd100};
        req_valid = '1;
        w = rr_pick(req_valid);
        serve(w, OUT_IRQ, 20, 1'b0, r0, d0);
        req_valid[w] = 1'b1;
        w = rr_pick(req_valid);
        serve(w, OUT_IRQ, 30, 1'b0, r1, d1);
        total++;
        if (r1 - d0 < 1 || r1 - d0 > 2) begin
            bad++;
            $display("FAIL rearb_gap: got %0d cycles done->ready want 1..2", r1 - d0);
        end
        w = rr_pick(req_valid);
        serve(w, OUT_IRQ, 5, 1'b0, r2, d2);
    endtask

    task automatic test_cancel();
        int r, d;
        req_period[63:32] = 32'd1000;
        req_valid[1] = 1'b1;
        serve(rr_pick(req_valid), OUT_CANCEL, 50, 1'b1, r, d);
    endtask

    task automatic test_race();
        int r, d;
        req_period[31:0] = $urandom_range(1, 32'h00FF_FFFF);
        req_valid[0] = 1'b1;
        serve(rr_pick(req_valid), OUT_RACE, 7, 1'b0, r, d);
    endtask

    task automatic test_zero();
        int r, d;
        req_period[31:0] = 32'd0;
        req_valid[0] = 1'b1;
        serve(rr_pick(req_valid), OUT_IRQ, 0, 1'b0, r, d);
    endtask

    task automatic test_random();
        int w, outcome, dly, r, d;
        logic [N-1:0] mask;
        for (int round = 0; round < 12; round++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                req_period[32*i +: 32] = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            end
            req_valid = mask;
            while (req_valid != '0) begin
                w = rr_pick(req_valid);
                outcome = $urandom_range(0, 2);
                dly = $urandom_range(1, 40);
                // A cancel before the grant is not remembered.
                if ($urandom_range(0, 3) == 0) req_cancel[w] = 1'b1;
                serve(w, outcome, dly, (dly >= 4) && ($urandom_range(0, 1) == 1), r, d);
            end
        end
    endtask

    initial begin
        tmr_bus.tmr_irq = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_cancel();
        test_race();
        test_zero();
        test_random();
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no completion want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
